// File: rtl/uart_tx_param.sv
// ----------------------------------------------------------------------------
// uart_tx_param
//   Parametrised UART transmitter. Serialises DATA_W-bit words as
//   start / data (LSB first) / optional parity / STOP_BITS stop bits, with an
//   internal baud divider and a ready/valid input handshake.
//
//   Build option: UART_TX_FIFO_EN
//     defined   -> FIFO_DEPTH-entry circular FIFO in front of the serialiser
//     undefined -> single-entry holding register (FIFO_DEPTH ignored)
//
// Parameters
//   DATA_W        data bits per frame (5..9)
//   CLKS_PER_BIT  clk cycles per serial bit (>= 2)
//   STOP_BITS     stop bits per frame (1 or 2)
//   FIFO_DEPTH    FIFO entries, power of 2 >= 2 (FIFO build only)
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous, active-high reset
//   tx_valid     producer offers tx_data
//   tx_ready     a word can be accepted this cycle (buffer not full)
//   tx_data      word to transmit
//   parity_mode  00 none, 01 even, 10 odd, 11 none; sampled when a word starts
//   tx_out       serial line, idle high
//   tx_busy      a frame is in progress
//   tx_done      one-cycle pulse in the cycle after the last stop-bit cycle
//   fifo_level   words buffered and not yet started
// ----------------------------------------------------------------------------
module uart_tx_param #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    input  logic [DATA_W-1:0]               tx_data,
    input  logic [1:0]                      parity_mode,
    output logic                            tx_out,
    output logic                            tx_busy,
    output logic                            tx_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_W);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // ------------------------------------------------------------------
    // Input buffer (FIFO or single holding register)
    // ------------------------------------------------------------------
    logic              push;
    logic              pop;
    logic              buf_empty;
    logic              buf_full;
    logic [DATA_W-1:0] buf_head;

    // tx_ready depends only on registered occupancy, never on tx_valid.
    assign tx_ready = ~buf_full;
    assign push     = tx_valid & tx_ready;

`ifdef UART_TX_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  count;

    // Storage carries no reset; stale entries are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // Depth is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign buf_empty  = (count == '0);
    assign buf_full   = (count == LVL_W'(FIFO_DEPTH));
    assign buf_head   = mem[rd_ptr];
    assign fifo_level = count;
`else
    logic [DATA_W-1:0] hold_data;
    logic              hold_vld;

    always_ff @(posedge clk) begin
        if (push) begin
            hold_data <= tx_data;
        end
    end

    // Push needs an empty register and pop needs a full one, so the two
    // can never coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_vld <= 1'b0;
        end else if (push) begin
            hold_vld <= 1'b1;
        end else if (pop) begin
            hold_vld <= 1'b0;
        end
    end

    assign buf_empty  = ~hold_vld;
    assign buf_full   = hold_vld;
    assign buf_head   = hold_data;
    assign fifo_level = {{(LVL_W-1){1'b0}}, hold_vld};
`endif

    // ------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------
    logic [2:0]        state;
    logic [2:0]        state_n;
    logic [CNT_W-1:0]  baud_cnt;
    logic [CNT_W-1:0]  baud_n;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BIT_W-1:0]  bit_n;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_n;
    logic              par_en;
    logic              par_en_n;
    logic              par_bit;
    logic              par_bit_n;
    logic              line_n;

    logic baud_last;
    logic data_last;
    logic stop_last;
    logic frame_end;

    assign baud_last = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign data_last = (bit_cnt == BIT_W'(DATA_W - 1));
    assign stop_last = (bit_cnt == BIT_W'(STOP_BITS - 1));
    assign frame_end = (state == S_STOP) && baud_last && stop_last;

    // A word starts from IDLE, or straight out of the last stop cycle so
    // back-to-back frames have no idle gap.
    assign pop = ~buf_empty & ((state == S_IDLE) | frame_end);

    always_comb begin
        state_n   = state;
        baud_n    = baud_cnt + CNT_W'(1);
        bit_n     = bit_cnt;
        shreg_n   = shreg;
        par_en_n  = par_en;
        par_bit_n = par_bit;

        if (pop) begin
            state_n   = S_START;
            baud_n    = '0;
            bit_n     = '0;
            shreg_n   = buf_head;
            par_en_n  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
            par_bit_n = (^buf_head) ^ (parity_mode == 2'b10);
        end else begin
            case (state)
                S_IDLE: begin
                    baud_n = '0;
                end
                S_START: begin
                    if (baud_last) begin
                        state_n = S_DATA;
                        baud_n  = '0;
                        bit_n   = '0;
                    end
                end
                S_DATA: begin
                    if (baud_last) begin
                        baud_n = '0;
                        if (data_last) begin
                            state_n = par_en ? S_PARITY : S_STOP;
                            bit_n   = '0;
                        end else begin
                            bit_n   = bit_cnt + BIT_W'(1);
                            shreg_n = shreg >> 1;
                        end
                    end
                end
                S_PARITY: begin
                    if (baud_last) begin
                        state_n = S_STOP;
                        baud_n  = '0;
                        bit_n   = '0;
                    end
                end
                S_STOP: begin
                    if (baud_last) begin
                        baud_n = '0;
                        if (stop_last) begin
                            state_n = S_IDLE;
                        end else begin
                            bit_n = bit_cnt + BIT_W'(1);
                        end
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    baud_n  = '0;
                    bit_n   = '0;
                end
            endcase
        end
    end

    // tx_out is registered from the next-state view so the pad sees a
    // glitch-free line aligned with the state register.
    always_comb begin
        case (state_n)
            S_START:  line_n = 1'b0;
            S_DATA:   line_n = shreg_n[0];
            S_PARITY: line_n = par_bit_n;
            default:  line_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_en   <= 1'b0;
            par_bit  <= 1'b0;
            tx_out   <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shreg    <= shreg_n;
            par_en   <= par_en_n;
            par_bit  <= par_bit_n;
            tx_out   <= line_n;
            tx_done  <= frame_end;
        end
    end

    assign tx_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_param.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_param
//   Two transmitters (8 data bits / 1 stop, and 5 data bits / 2 stops) share
//   one stimulus stream. A frame-level model predicts every output each cycle;
//   directed sequences add literal checks on known frames.
// ----------------------------------------------------------------------------
module tb_uart_tx_param;

    localparam int CPB  = 4;
    localparam int DW0  = 8;
    localparam int SB0  = 1;
    localparam int DW1  = 5;
    localparam int SB1  = 2;
    localparam int FD   = 4;
    localparam int LW   = $clog2(FD + 1);
    localparam int LOGN = 1024;
`ifdef UART_TX_FIFO_EN
    localparam int CAP = FD;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic [1:0]    parity_mode;
    logic          rdy0, out0, busy0, done0;
    logic          rdy1, out1, busy1, done1;
    logic [LW-1:0] lvl0, lvl1;

    uart_tx_param #(.DATA_W(DW0), .CLKS_PER_BIT(CPB), .STOP_BITS(SB0), .FIFO_DEPTH(FD)) dut0 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(rdy0), .tx_data(tx_data),
        .parity_mode(parity_mode), .tx_out(out0), .tx_busy(busy0), .tx_done(done0),
        .fifo_level(lvl0));

    uart_tx_param #(.DATA_W(DW1), .CLKS_PER_BIT(CPB), .STOP_BITS(SB1), .FIFO_DEPTH(FD)) dut1 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(rdy1), .tx_data(tx_data[DW1-1:0]),
        .parity_mode(parity_mode), .tx_out(out1), .tx_busy(busy1), .tx_done(done1),
        .fifo_level(lvl1));

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;

    function automatic void chk(string name, int act, int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // ---------------- behavioural model ----------------
    int          dwa [2] = '{DW0, DW1};
    int          sba [2] = '{SB0, SB1};
    int unsigned qbuf[2][8];
    int          qn  [2];
    bit          act [2];
    int          tt  [2];
    int          flen[2];
    logic [15:0] fb  [2];
    bit          mdone[2];
    bit          mvalid = 1'b0;

    // Frame as a list of line levels, one per bit period.
    function automatic void start_frame(int d, int unsigned w, logic [1:0] pm);
        int n;
        int par;
        fb[d]    = '1;
        fb[d][0] = 1'b0;
        for (int i = 0; i < dwa[d]; i++) fb[d][1+i] = w[i];
        n = 1 + dwa[d];
        if (pm == 2'b01 || pm == 2'b10) begin
            par = $countones(w) % 2;
            if (pm == 2'b10) par = 1 - par;
            fb[d][n] = par[0];
            n++;
        end
        flen[d] = n + sba[d];
        act[d]  = 1'b1;
        tt[d]   = 0;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                qn[d] = 0; act[d] = 1'b0; mdone[d] = 1'b0;
            end
            mvalid = 1'b1;
        end else begin
            for (int d = 0; d < 2; d++) begin
                bit          ne, fl, popn;
                int unsigned w;
                ne = (qn[d] > 0);
                fl = (qn[d] >= CAP);
                popn = 1'b0;
                mdone[d] = 1'b0;
                if (act[d]) begin
                    if (tt[d] == flen[d] * CPB - 1) begin
                        mdone[d] = 1'b1;
                        act[d]   = 1'b0;
                        popn     = ne;
                    end else begin
                        tt[d]++;
                    end
                end else begin
                    popn = ne;
                end
                if (popn) begin
                    w = qbuf[d][0];
                    for (int k = 0; k < 7; k++) qbuf[d][k] = qbuf[d][k+1];
                    qn[d]--;
                    start_frame(d, w, parity_mode);
                end
                if (tx_valid && !fl) begin
                    qbuf[d][qn[d]] = 32'(tx_data) & ((32'd1 << dwa[d]) - 1);
                    qn[d]++;
                end
            end
        end
    end

    // ---------------- per-cycle compare + trace log ----------------
    logic lo0[LOGN], ld0[LOGN], lr0[LOGN], lb0[LOGN];
    logic lo1[LOGN], ld1[LOGN];
    int   ll0[LOGN];

    always @(negedge clk) begin
        int ix;
        ix = cyc % LOGN;
        lo0[ix] = out0; ld0[ix] = done0; lr0[ix] = rdy0; lb0[ix] = busy0; ll0[ix] = int'(lvl0);
        lo1[ix] = out1; ld1[ix] = done1;
        if (mvalid) begin
            for (int d = 0; d < 2; d++) begin
                logic ao, ab, ad, ar, eo;
                int   al;
                ao = (d == 0) ? out0  : out1;
                ab = (d == 0) ? busy0 : busy1;
                ad = (d == 0) ? done0 : done1;
                ar = (d == 0) ? rdy0  : rdy1;
                al = (d == 0) ? int'(lvl0) : int'(lvl1);
                eo = act[d] ? fb[d][tt[d] / CPB] : 1'b1;
                chk($sformatf("dut%0d tx_out", d),     int'(ao), int'(eo));
                chk($sformatf("dut%0d tx_busy", d),    int'(ab), int'(act[d]));
                chk($sformatf("dut%0d tx_done", d),    int'(ad), int'(mdone[d]));
                chk($sformatf("dut%0d tx_ready", d),   int'(ar), (qn[d] < CAP) ? 1 : 0);
                chk($sformatf("dut%0d fifo_level", d), al, qn[d]);
            end
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        tx_valid = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            if (!busy0 && !busy1 && lvl0 == '0 && lvl1 == '0) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) chk("wait_idle timeout", 1, 0);
    endtask

    // Holds tx_valid until dut0 accepts; acc = log index of the cycle after acceptance.
    task automatic push(input logic [7:0] w, output int acc);
        acc = -1;
        tx_valid = 1'b1;
        tx_data  = w;
        for (int i = 0; i < 400 && acc < 0; i++) begin
            if (rdy0) acc = cyc + 1;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        if (acc < 0) begin
            chk("push timeout", 1, 0);
            acc = cyc;
        end
    endtask

    function automatic int L(int i);
        return i % LOGN;
    endfunction

    // ---------------- directed + random sequences ----------------
    initial begin
        int          a, a1, a2, n, peak;
        logic [9:0]  ln;
        rst = 1'b1; tx_valid = 1'b0; tx_data = '0; parity_mode = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset held two cycles while idle
        wait_cyc(3);
        rst = 1'b1;
        wait_cyc(2);
        chk("reset tx_out", int'(out0), 1);
        chk("reset tx_busy", int'(busy0), 0);
        chk("reset tx_ready", int'(rdy0), 1);
        chk("reset tx_done", int'(done0), 0);
        chk("reset fifo_level", int'(lvl0), 0);
        rst = 1'b0;

        // 0xA5, no parity: line pattern, bit width, done position
        parity_mode = 2'b00;
        wait_idle();
        push(8'hA5, a);
        wait_cyc(52);
        ln = 10'b1101001010;
        chk("A5 still idle after accept", int'(lo0[L(a)]), 1);
        for (int c = 0; c < 40; c++)
            chk($sformatf("A5 line c%0d", c), int'(lo0[L(a+1+c)]), int'(ln[c/4]));
        n = 0;
        for (int k = 0; k < 50; k++) n += int'(ld0[L(a+k)]);
        chk("A5 done count", n, 1);
        chk("A5 done position", int'(ld0[L(a+41)]), 1);

        // 0x07 with even then odd parity; dut1 shows the two stop bits
        for (int m = 1; m <= 2; m++) begin
            parity_mode = 2'(m);
            wait_idle();
            push(8'h07, a);
            wait_cyc(52);
            chk($sformatf("07 pm%0d dut0 parity", m), int'(lo0[L(a+1+38)]), (m == 1) ? 1 : 0);
            chk($sformatf("07 pm%0d dut0 done", m), int'(ld0[L(a+45)]), 1);
            chk($sformatf("07 pm%0d dut1 parity", m), int'(lo1[L(a+1+26)]), (m == 1) ? 1 : 0);
            n = 0;
            for (int c = 28; c < 36; c++) n += int'(lo1[L(a+1+c)]);
            chk($sformatf("07 pm%0d dut1 stop highs", m), n, 8);
            chk($sformatf("07 pm%0d dut1 done", m), int'(ld1[L(a+37)]), 1);
        end

        // 0x55 then 0xAA back-to-back
        parity_mode = 2'b00;
        wait_idle();
        push(8'h55, a1);
        push(8'hAA, a2);
        wait_cyc(100);
        chk("55/AA accept gap", a2 - a1, (CAP == 1) ? 2 : 1);
        chk("55 last stop high", int'(lo0[L(a1+40)]), 1);
        chk("AA start right after stop", int'(lo0[L(a1+41)]), 0);
        chk("55 done with AA start", int'(ld0[L(a1+41)]), 1);
        chk("ready while AA held", int'(lr0[L(a1+20)]), (CAP == 1) ? 0 : 1);
        chk("level while AA held", ll0[L(a1+20)], 1);
        chk("ready after AA pop", int'(lr0[L(a1+41)]), 1);
        ln = 10'b1101010100;
        for (int c = 0; c < 40; c += 2)
            chk($sformatf("AA line c%0d", c), int'(lo0[L(a1+41+c)]), int'(ln[c/4]));

        // Five words with tx_valid held
        wait_idle();
        push(8'h11, a);
        push(8'h22, n);
        push(8'h33, n);
        push(8'h44, n);
        push(8'h55, n);
        wait_idle();
        wait_cyc(2);
        peak = 0; n = 0; a1 = 0;
        for (int k = a; k < cyc - 1; k++) begin
            if (ll0[L(k)] > peak) peak = ll0[L(k)];
            if (ll0[L(k)] == CAP && lr0[L(k)]) n++;
            a1 += int'(ld0[L(k)]);
        end
        chk("burst peak level", peak, CAP);
        chk("burst ready while full", n, 0);
        chk("burst frames done", a1, 5);

        // Reset during data bit 3 of 0xFF with a word buffered
        wait_idle();
        push(8'hFF, a1);
        push(8'h81, a2);
        for (int i = 0; i < 100 && cyc < a1 + 18; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_cyc(62);
        chk("rst mid-frame tx_out", int'(lo0[L(a1+19)]), 1);
        chk("rst mid-frame busy", int'(lb0[L(a1+19)]), 0);
        chk("rst mid-frame level", ll0[L(a1+19)], 0);
        n = 0; peak = 0;
        for (int k = a1 + 19; k < a1 + 79; k++) begin
            n += int'(ld0[L(k)]);
            peak += int'(!lo0[L(k)]);
        end
        chk("rst mid-frame no done", n, 0);
        chk("rst mid-frame line quiet", peak, 0);
        push(8'h3C, a);
        wait_cyc(45);
        ln = 10'b1001111000;
        for (int c = 0; c < 40; c++)
            chk($sformatf("3C line c%0d", c), int'(lo0[L(a+1+c)]), int'(ln[c/4]));

        // Random traffic, parity changing every cycle, rare resets
        for (int i = 0; i < 4000; i++) begin
            tx_valid    = ($urandom_range(0, 2) == 0);
            tx_data     = 8'($urandom);
            parity_mode = 2'($urandom);
            rst         = ($urandom_range(0, 599) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        wait_idle();
        wait_cyc(4);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
